// File: rtl/seq_mult_param.sv
// Shift-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per cycle.
// Define MULT_SIGNED_EN to enable two's-complement operation selected per operation by tc_i.
module seq_mult_param #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 tc_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     magA, magB;
    logic                 resultSign_q, resultSign_d;
    logic                 acceptSign;
    logic [2*WIDTH-1:0]   finalProduct;
    logic [WIDTH:0]       partialSum;

`ifdef MULT_SIGNED_EN
    // Negation of the most-negative value wraps to itself, which reads correctly as unsigned.
    assign magA         = (tc_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign magB         = (tc_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign acceptSign   = tc_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    assign finalProduct = resultSign_q ? -acc_q : acc_q;
`else
    logic unusedTc;
    assign unusedTc     = tc_i;
    assign magA         = a_i;
    assign magB         = b_i;
    assign acceptSign   = 1'b0;
    assign finalProduct = acc_q;
`endif

    // Upper half plus optional multiplicand, keeping the carry bit for the shift.
    assign partialSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        product_d    = product_q;
        resultSign_d = resultSign_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d      = magA;
                    mplier_d     = magB;
                    resultSign_d = acceptSign;
                    acc_d        = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                acc_d    = {partialSum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                product_d = finalProduct;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            product_q    <= '0;
            resultSign_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            product_q    <= product_d;
            resultSign_q <= resultSign_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: a WIDTH=4 instance for most scenarios plus a WIDTH=8 instance.
// Signed-mode scenarios are compiled only when MULT_SIGNED_EN is defined.
module tb_seq_mult_param;

    logic        clk;
    logic        rst_n;

    logic        start4, tc4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  prod4;

    logic        start8, tc8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    int compared;
    int mismatched;

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start4),
        .a_i       (a4),
        .b_i       (b4),
        .tc_i      (tc4),
        .busy_o    (busy4),
        .done_o    (done4),
        .product_o (prod4)
    );

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start8),
        .a_i       (a8),
        .b_i       (b8),
        .tc_i      (tc8),
        .busy_o    (busy8),
        .done_o    (done8),
        .product_o (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic tc);
        a4     = a;
        b4     = b;
        tc4    = tc;
        start4 = 1'b1;
    endtask

    // Starts one operation on the WIDTH=4 unit and waits (bounded) for its done pulse.
    task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic tc,
                         output logic [7:0] prod, output bit seen);
        prod = 8'hxx;
        seen = 1'b0;
        applyStimulus(a, b, tc);
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(posedge clk); #1;
            if (done4) begin
                seen = 1'b1;
                prod = prod4;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; tc4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; tc8 = 1'b0;
        #12;
        compared++;
        if ({busy4, done4, prod4} !== 10'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_w4: got busy=%b done=%b product=%h expected 0/0/00", busy4, done4, prod4);
        end
        compared++;
        if ({busy8, done8, prod8} !== 18'h00000) begin
            mismatched++;
            $display("[TB] FAIL reset_w8: got busy=%b done=%b product=%h expected 0/0/0000", busy8, done8, prod8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic expBusy, expDone;
        applyStimulus(4'd7, 4'd13, 1'b0);
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'd1; b4 = 4'd1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            expBusy = (k < 5);
            expDone = (k == 5);
            compared++;
            if (busy4 !== expBusy || done4 !== expDone) begin
                mismatched++;
                $display("[TB] FAIL basic_handshake k=%0d: got busy=%b done=%b expected busy=%b done=%b",
                         k, busy4, done4, expBusy, expDone);
            end
            if (k == 2) begin
                compared++;
                if (prod4 !== 8'h00) begin
                    mismatched++;
                    $display("[TB] FAIL basic_product_during_run: got %h expected 00", prod4);
                end
            end
            if (k == 5) begin
                compared++;
                if (prod4 !== 8'h5B) begin
                    mismatched++;
                    $display("[TB] FAIL basic_product: got %h expected 5b", prod4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(4'd15, 4'd15, 1'b0);
        @(posedge clk); #1;
        a4 = 4'd0; b4 = 4'd9;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            compared++;
            if (done4 !== (k == 5 || k == 11)) begin
                mismatched++;
                $display("[TB] FAIL b2b_done k=%0d: got %b expected %b", k, done4, (k == 5 || k == 11));
            end
            if (k == 5 || k == 8) begin
                compared++;
                if (prod4 !== 8'hE1) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_first_product k=%0d: got %h expected e1", k, prod4);
                end
            end
            if (k == 11) begin
                compared++;
                if (prod4 !== 8'h00) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_second_product: got %h expected 00", prod4);
                end
                start4 = 1'b0;
            end
        end
        compared++;
        if (busy4 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_idle_after: got busy=%b expected 0", busy4);
        end
    endtask

    task automatic test_ignore_busy_start();
        int doneCount;
        doneCount = 0;
        applyStimulus(4'd3, 4'd5, 1'b0);
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done4) doneCount++;
            if (k == 2) begin
                a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
            end
            if (k == 3) start4 = 1'b0;
            if (k == 5) begin
                compared++;
                if (prod4 !== 8'h0F || done4 !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL ignore_product: got done=%b product=%h expected 1/0f", done4, prod4);
                end
            end
        end
        compared++;
        if (doneCount !== 1) begin
            mismatched++;
            $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount);
        end
        compared++;
        if (prod4 !== 8'h0F) begin
            mismatched++;
            $display("[TB] FAIL ignore_product_held: got %h expected 0f", prod4);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] p;
        bit         seen;
        applyStimulus(4'd6, 4'd6, 1'b0);
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        compared++;
        if (busy4 !== 1'b0 || prod4 !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL abort_async_clear: got busy=%b product=%h expected 0/00", busy4, prod4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            compared++;
            if (done4 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL abort_no_done k=%0d: got %b expected 0", k, done4);
            end
        end
        compared++;
        if (busy4 !== 1'b0 || prod4 !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL abort_idle: got busy=%b product=%h expected 0/00", busy4, prod4);
        end
        runOp(4'd2, 4'd3, 1'b0, p, seen);
        compared++;
        if (!seen || p !== 8'h06) begin
            mismatched++;
            $display("[TB] FAIL abort_next_op: got seen=%b product=%h expected 1/06", seen, p);
        end
    endtask

    task automatic test_width8();
        a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'd0; b8 = 8'd0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            compared++;
            if (done8 !== (k == 9)) begin
                mismatched++;
                $display("[TB] FAIL w8_done k=%0d: got %b expected %b", k, done8, (k == 9));
            end
        end
        compared++;
        if (prod8 !== 16'hFE01) begin
            mismatched++;
            $display("[TB] FAIL w8_product: got %h expected fe01", prod8);
        end
    endtask

    task automatic test_tc_mode();
        logic [7:0] p;
        bit         seen;
`ifdef MULT_SIGNED_EN
        runOp(4'hD, 4'h5, 1'b1, p, seen);
        compared++;
        if (!seen || p !== 8'hF1) begin
            mismatched++;
            $display("[TB] FAIL signed_neg3x5: got seen=%b product=%h expected 1/f1", seen, p);
        end
        runOp(4'h8, 4'h8, 1'b1, p, seen);
        compared++;
        if (!seen || p !== 8'h40) begin
            mismatched++;
            $display("[TB] FAIL signed_neg8xneg8: got seen=%b product=%h expected 1/40", seen, p);
        end
        runOp(4'h3, 4'hE, 1'b1, p, seen);
        compared++;
        if (!seen || p !== 8'hFA) begin
            mismatched++;
            $display("[TB] FAIL signed_3xneg2: got seen=%b product=%h expected 1/fa", seen, p);
        end
`else
        runOp(4'hD, 4'h5, 1'b1, p, seen);
        compared++;
        if (!seen || p !== 8'h41) begin
            mismatched++;
            $display("[TB] FAIL tc_ignored: got seen=%b product=%h expected 1/41", seen, p);
        end
`endif
        runOp(4'hD, 4'h5, 1'b0, p, seen);
        compared++;
        if (!seen || p !== 8'h41) begin
            mismatched++;
            $display("[TB] FAIL unsigned_13x5: got seen=%b product=%h expected 1/41", seen, p);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy_start();
        test_reset_abort();
        test_width8();
        test_tc_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised shift-add sequential multiplier.
- Next generation of the fixed 4x4 start/operand/product multiplier datapath.
- Adds configurable operand width, busy/done handshake, product hold register and optional two's-complement mode.
- Used standalone or as an FPGA datapath unit driven by a controller issuing start pulses.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request; sampled on rising clk edge
a  input  WIDTH  multiplicand, captured when start accepted
b  input  WIDTH  multiplier, captured when start accepted
tc  input  1  two's-complement mode select, captured with operands (see Optional Feature)
busy  output  1  high while a multiplication is in progress
done  output  1  single-cycle pulse, product valid
product  output  2*WIDTH  result; held stable until the next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, product=0; internal accumulator, operand registers and counter cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge -> capture a, b, tc; clear accumulator and counter; busy=1; go RUN.
  - start=0 -> stay in IDLE.
- RUN: one iteration per clk.
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator, keeping the carry (WIDTH+1-bit add).
  - Shift the accumulator right by one; the counter increments.
  - After exactly WIDTH RUN cycles -> FIN.
- FIN, one cycle:
  - product <= final accumulator (sign-corrected if applicable); done=1; busy=0.
  - Next edge -> IDLE, with done back to 0.
  - product does not change again until the next accepted start completes.
- Latency: start accepted at edge E0 -> done high during the cycle after edge E0+WIDTH+1. Total is WIDTH+2 cycles from start-edge to done deassertion.
- start while busy=1 (RUN or FIN) is ignored; operands are not recaptured.
- start held high continuously: a new operation is accepted on the first IDLE edge after FIN, giving back-to-back operations every WIDTH+2 cycles.
- a, b and tc may change freely after acceptance without effect.
- Arithmetic is exact for all operand pairs; no overflow is possible in 2*WIDTH bits.
- Zero operands take the full WIDTH iterations (no early exit).
- The product register is updated only in FIN; during RUN the previous product stays visible.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined, tc=1:
  - a and b are treated as signed two's-complement values.
  - At acceptance, negative operands are replaced by their magnitudes and result_sign = a[MSB]^b[MSB] is registered.
  - In FIN, product = result_sign ? -magnitude_product : magnitude_product.
  - The most-negative WIDTH-bit value is handled correctly: the magnitude uses the unsigned interpretation, so WIDTH=4 gives -8*-8 = +64 = 8'h40.
  - Latency is unchanged.
- Defined, tc=0: unsigned behaviour.
- Not defined: tc is ignored (port still present); all operations are unsigned; no sign logic is synthesised.

Test Plan:
- WIDTH=4, reset then start=1 for one cycle with a=7, b=13 -> done pulses exactly 6 cycles after the start edge; product=8'h5B (91); busy high for 5 cycles.
- WIDTH=4, a=15, b=15, then a=0, b=9 back-to-back with start held high -> product=8'hE1, then 8'h00; consecutive done pulses 6 cycles apart.
- WIDTH=4, start a=3, b=5, pulse start again with a=9, b=9 two cycles later -> second start ignored; product=8'h0F; only one done.
- WIDTH=4, start a=6, b=6, assert rst=0 three cycles in, release, wait 10 cycles -> busy=0, done never pulses, product=0; the next start with a=2, b=3 gives 8'h06.
- WIDTH=8, a=255, b=255 -> product=16'hFE01 after 10 cycles.
- MULT_SIGNED_EN defined, WIDTH=4:
  - tc=1, a=4'hD (-3), b=5 -> 8'hF1 (-15).
  - tc=1, a=4'h8, b=4'h8 -> 8'h40.
  - tc=0, a=4'hD, b=5 -> 8'h41 (65).
